// File: rtl/hex_scan_pkg.sv
// ============================================================================
//  Module   : hex_scan_pkg
//  Brief    : Shared constants for the seven-segment hex scanner: segment
//             font, dark pattern and PWM step helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hex_scan_pkg;

    // Segment pattern {a,b,c,d,e,f,g,dp}, active-low
    typedef logic [7:0] seg_t;

    // All segments off
    localparam seg_t SEG_OFF = 8'hFF;

    // Hex font with the decimal point off; bit0 is replaced by the dp logic
    localparam seg_t FONT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
        8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
        8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
        8'h63, 8'h85, 8'h61, 8'h71    // C d E F
    };

    // Lit cycles contributed by one brightness code step
    function automatic int step(input int div, input int guard, input int bright_w);
        return (div - guard) >> bright_w;
    endfunction

endpackage : hex_scan_pkg

`default_nettype wire

// File: rtl/hex_seg_font.sv
// ============================================================================
//  Module   : hex_seg_font
//  Brief    : Combinational hex nibble + decimal point to active-low
//             seven-segment pattern {a,b,c,d,e,f,g,dp}.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_seg_font
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    seg_t w_glyph;

    // Font lookup; the dp segment is lit (low) when dp is set
    always_comb begin
        w_glyph = FONT[nibble];
        seg     = {w_glyph[7:1], ~dp};
    end

endmodule : hex_seg_font

`default_nettype wire

// File: rtl/hex_display_scanner.sv
// ============================================================================
//  Module   : hex_display_scanner
//  Brief    : Time-multiplexed common-anode seven-segment hex driver with
//             per-frame input snapshot, anti-ghosting guard and PWM dimming.
//             Define HEXSCAN_LZS_EN to add the lzs (leading-zero suppression)
//             input port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_display_scanner
    import hex_scan_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int DIV      = 1024,
    parameter int GUARD    = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    input  logic [BRIGHT_W-1:0]   bright,
`ifdef HEXSCAN_LZS_EN
    input  logic                  lzs,
`endif
    output logic [DIGITS-1:0]     id,
    output logic [7:0]            out,
    output logic                  frame
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_dig_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);
    localparam logic [c_dig_w-1:0] c_dig_last = c_dig_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_dig_one  = DIGITS'(1);
    localparam logic [31:0]        c_guard    = 32'(GUARD);
    localparam logic [31:0]        c_step     = 32'(step(DIV, GUARD, BRIGHT_W));

    // State
    logic [c_cnt_w-1:0]  r_cnt_q;
    logic [c_dig_w-1:0]  r_dig_q;
    logic [4*DIGITS-1:0] r_in_q;
    logic [DIGITS-1:0]   r_blank_q;
    logic [DIGITS-1:0]   r_dp_q;
    logic [DIGITS-1:0]   r_id_q;
    logic [7:0]          r_out_q;
    logic                r_frame_q;

    // Next-state
    logic [c_cnt_w-1:0]  w_cnt_d;
    logic [c_dig_w-1:0]  w_dig_d;
    logic [4*DIGITS-1:0] w_in_d;
    logic [DIGITS-1:0]   w_blank_d;
    logic [DIGITS-1:0]   w_dp_d;
    logic [DIGITS-1:0]   w_id_d;
    logic [7:0]          w_out_d;
    logic                w_frame_d;

    logic                w_snap;
    logic [DIGITS-1:0]   w_supp;
    logic [31:0]         w_cnt_wide;
    logic [31:0]         w_on_lim;
    logic                w_lit;
    logic [3:0]          w_nibble;
    logic                w_dp_cur;
    logic [7:0]          w_glyph;

    // Slot counter and digit index; both held at zero while disabled
    always_comb begin
        w_cnt_d = r_cnt_q;
        w_dig_d = r_dig_q;
        if (!en) begin
            w_cnt_d = '0;
            w_dig_d = '0;
        end else if (r_cnt_q == c_cnt_last) begin
            w_cnt_d = '0;
            w_dig_d = (r_dig_q == c_dig_last) ? '0 : r_dig_q + 1'b1;
        end else begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Frame snapshot of value, blank and dp at the start of digit 0's slot
    always_comb begin
        w_snap    = en && (r_cnt_q == '0) && (r_dig_q == '0);
        w_in_d    = w_snap ? in    : r_in_q;
        w_blank_d = w_snap ? blank : r_blank_q;
        w_dp_d    = w_snap ? dp    : r_dp_q;
    end

`ifdef HEXSCAN_LZS_EN
    logic w_run;

    // Leading-zero suppression: walk down from the top digit while the digit
    // is a zero without dp; digit 0 always stays visible
    always_comb begin
        w_supp = '0;
        w_run  = lzs;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run     = w_run && (r_in_q[4*i +: 4] == 4'h0) && !r_dp_q[i];
            w_supp[i] = w_run;
        end
    end
`else
    assign w_supp = '0;
`endif

    // Current digit's glyph from the shadow registers
    always_comb begin
        w_nibble = r_in_q[{r_dig_q, 2'b00} +: 4];
        w_dp_cur = r_dp_q[r_dig_q];
    end

    hex_seg_font u_font (
        .nibble (w_nibble),
        .dp     (w_dp_cur),
        .seg    (w_glyph)
    );

    // PWM window after the dark guard; bright is sampled live every cycle
    always_comb begin
        w_cnt_wide = 32'(r_cnt_q);
        w_on_lim   = c_guard + 32'(bright) * c_step;
        w_lit      = en
                     && (w_cnt_wide >= c_guard)
                     && (w_cnt_wide <  w_on_lim)
                     && !r_blank_q[r_dig_q]
                     && !w_supp[r_dig_q];
        w_id_d     = w_lit ? ~(c_dig_one << r_dig_q) : '1;
        w_out_d    = w_lit ? w_glyph : SEG_OFF;
        w_frame_d  = w_snap;
    end

    // State and registered outputs, asynchronously reset to dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q   <= '0;
            r_dig_q   <= '0;
            r_in_q    <= '0;
            r_blank_q <= '0;
            r_dp_q    <= '0;
            r_id_q    <= '1;
            r_out_q   <= SEG_OFF;
            r_frame_q <= 1'b0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_dig_q   <= w_dig_d;
            r_in_q    <= w_in_d;
            r_blank_q <= w_blank_d;
            r_dp_q    <= w_dp_d;
            r_id_q    <= w_id_d;
            r_out_q   <= w_out_d;
            r_frame_q <= w_frame_d;
        end
    end

    assign id    = r_id_q;
    assign out   = r_out_q;
    assign frame = r_frame_q;

endmodule : hex_display_scanner

`default_nettype wire
